req_fifo: RTL and testbench

Single-clock request FIFO that carries memory requests (address, write data, byte mask, write flag) toward the memory side, the opposite direction of the response path. Adds read-credit throttling: no more than MAX_OUTSTANDING reads leave the FIFO until matching responses are reported back. It sits between the request issuer and the memory-controller command port.

---
 rtl/req_pkg.sv | 16 +
 rtl/req_fifo_if.sv | 29 ++
 rtl/req_fifo_mem.sv | 25 ++
 rtl/req_fifo.sv | 87 ++++++++
 tb/tb_req_fifo.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/req_pkg.sv
// Shared request types for the memory-side request FIFO.
// A request is one packed word so storage and ports move it as a unit.
package req_pkg;

   localparam int REQ_ADDR_W = 32;
   localparam int REQ_DATA_W = 128;
   localparam int REQ_MASK_W = 16;

   typedef struct packed {
      logic [REQ_ADDR_W-1:0] addr;
      logic [REQ_DATA_W-1:0] wdata;
      logic [REQ_MASK_W-1:0] wmask;
      logic                  wen;
   } req_t;

endpackage

// File: rtl/req_fifo_if.sv
// Push/pop/credit bundle of the request FIFO; master is the issuer/controller side.
// The slave modport is the FIFO itself.
interface req_fifo_if #(
   parameter int DEPTH = 16
);
   import req_pkg::*;

   logic                   push_valid;
   logic                   push_ready;
   req_t                   push_req;
   logic                   pop_valid;
   logic                   pop_ready;
   req_t                   pop_req;
   logic                   rsp_done;
   logic [$clog2(DEPTH):0] level;
   logic [7:0]             outstanding;
   logic                   underflow;

   modport master (
      output push_valid, push_req, pop_valid, rsp_done,
      input  push_ready, pop_ready, pop_req, level, outstanding, underflow
   );

   modport slave (
      input  push_valid, push_req, pop_valid, rsp_done,
      output push_ready, pop_ready, pop_req, level, outstanding, underflow
   );

endinterface

// File: rtl/req_fifo_mem.sv
// DEPTH x req_t simple dual-port storage: clocked write, combinational read.
// No latency on the read side so the FIFO head falls through; no backpressure here.
module req_fifo_mem
   import req_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  req_t                     wr_data,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output req_t                     rd_data
);

   req_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/req_fifo.sv
// Request FIFO with read-credit throttling; 1-cycle fall-through from push to pop.
// Push stalls only on full; pop stalls on empty or when a head read has no credit left.
module req_fifo
   import req_pkg::*;
#(
   parameter int DEPTH           = 16,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic       clk,
   input  logic       rst,
   req_fifo_if.slave  io
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] FULL_LVL   = LW'(DEPTH);
   localparam logic [7:0]    MAX_CREDIT = 8'(MAX_OUTSTANDING);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic [7:0]    outstanding;
   logic          underflow;
   req_t          head;
   logic          credit_stall;
   logic          push_fire;
   logic          pop_fire;
   logic          read_pop;

   req_fifo_mem #(.DEPTH(DEPTH)) u_mem (
      .clk     (clk),
      .wr_en   (push_fire),
      .wr_addr (wr_ptr),
      .wr_data (io.push_req),
      .rd_addr (rd_ptr),
      .rd_data (head)
   );

   // A read at the head with no credit blocks everything behind it, writes included.
   assign credit_stall = !head.wen && (outstanding == MAX_CREDIT);

   assign io.push_ready = !rst && (level != FULL_LVL);
   assign io.pop_ready  = !rst && (level != '0) && !credit_stall;

   assign push_fire = io.push_valid && io.push_ready;
   assign pop_fire  = io.pop_valid && io.pop_ready;
   assign read_pop  = pop_fire && !head.wen;

   assign io.pop_req     = head;
   assign io.level       = level;
   assign io.outstanding = outstanding;
   assign io.underflow   = underflow;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         level       <= '0;
         outstanding <= '0;
         underflow   <= 1'b0;
      end else begin
         if (push_fire)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_fire)
            rd_ptr <= rd_ptr + 1'b1;

         case ({push_fire, pop_fire})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase

         // A completion with nothing in flight is dropped and latched as an error.
         case ({read_pop, io.rsp_done})
            2'b10: outstanding <= outstanding + 8'd1;
            2'b01: begin
               if (outstanding == 8'd0)
                  underflow <= 1'b1;
               else
                  outstanding <= outstanding - 8'd1;
            end
            default: outstanding <= outstanding;
         endcase
      end
   end

endmodule

// File: tb/tb_req_fifo.sv
// Directed bench for req_fifo with a scoreboard queue checked by an independent pop monitor.
module tb_req_fifo;
   import req_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   int   pop_cnt = 0;
   req_t exp_q[$];

   always #5 clk = ~clk;

   req_fifo_if #(.DEPTH(16)) io_if ();

   req_fifo #(.DEPTH(16), .MAX_OUTSTANDING(4)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io_if)
   );

   function automatic req_t mk(input logic [31:0] addr, input logic wen);
      req_t r;
      r.addr  = addr;
      r.wdata = {addr, ~addr, addr ^ 32'h5a5a_a5a5, addr + 32'd7};
      r.wmask = addr[15:0] ^ 16'hf00f;
      r.wen   = wen;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_one(input req_t r);
      chk("push_ready_before_push", 32'(io_if.push_ready), 32'd1);
      io_if.push_valid = 1'b1;
      io_if.push_req   = r;
      exp_q.push_back(r);
      tick();
      io_if.push_valid = 1'b0;
   endtask

   // Monitor: a pop will happen at the next edge; compare head with the scoreboard.
   always @(negedge clk) begin
      if (io_if.pop_valid && io_if.pop_ready) begin
         pop_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got addr %0h expected no pop", io_if.pop_req.addr);
         end else begin
            if (io_if.pop_req !== exp_q[0]) begin
               errors++;
               $display("FAIL pop_data: got %0h expected %0h", io_if.pop_req, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      rst              = 1'b1;
      io_if.push_valid = 1'b0;
      io_if.push_req   = '0;
      io_if.pop_valid  = 1'b0;
      io_if.rsp_done   = 1'b0;
      tick();
      tick();
      chk("rst_push_ready", 32'(io_if.push_ready), 32'd0);
      chk("rst_pop_ready", 32'(io_if.pop_ready), 32'd0);
      chk("rst_level", 32'(io_if.level), 32'd0);
      chk("rst_outstanding", 32'(io_if.outstanding), 32'd0);
      chk("rst_underflow", 32'(io_if.underflow), 32'd0);
      rst = 1'b0;
      #1;
      chk("push_ready_after_rst", 32'(io_if.push_ready), 32'd1);

      // Single write falls through in one cycle.
      push_one(mk(32'h100, 1'b1));
      chk("ft_pop_ready", 32'(io_if.pop_ready), 32'd1);
      chk("ft_level", 32'(io_if.level), 32'd1);
      io_if.pop_valid = 1'b1;
      tick();
      io_if.pop_valid = 1'b0;
      chk("ft_level_after_pop", 32'(io_if.level), 32'd0);
      chk("ft_outstanding", 32'(io_if.outstanding), 32'd0);
      chk("ft_pop_ready_empty", 32'(io_if.pop_ready), 32'd0);

      // Fill to full, then a push alongside a pop is refused.
      for (int i = 0; i < 16; i++) push_one(mk(32'h200 + 32'(i), 1'b1));
      chk("full_level", 32'(io_if.level), 32'd16);
      chk("full_push_ready", 32'(io_if.push_ready), 32'd0);
      io_if.push_valid = 1'b1;
      io_if.push_req   = mk(32'h2ff, 1'b1);
      io_if.pop_valid  = 1'b1;
      tick();
      io_if.pop_valid = 1'b0;
      chk("full_refused_level", 32'(io_if.level), 32'd15);
      chk("full_push_ready_back", 32'(io_if.push_ready), 32'd1);
      exp_q.push_back(mk(32'h2ff, 1'b1));
      tick();
      io_if.push_valid = 1'b0;
      chk("full_level_again", 32'(io_if.level), 32'd16);
      io_if.pop_valid = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      io_if.pop_valid = 1'b0;
      chk("drain_level", 32'(io_if.level), 32'd0);
      chk("drain_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      // Six reads against four credits.
      for (int i = 0; i < 6; i++) push_one(mk(32'h300 + 32'(i), 1'b0));
      p0 = pop_cnt;
      io_if.pop_valid = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      chk("credit_pops", 32'(pop_cnt - p0), 32'd4);
      chk("credit_outstanding", 32'(io_if.outstanding), 32'd4);
      chk("credit_pop_ready", 32'(io_if.pop_ready), 32'd0);
      chk("credit_level", 32'(io_if.level), 32'd2);
      io_if.rsp_done = 1'b1;
      tick();
      io_if.rsp_done = 1'b0;
      chk("release_pop_ready", 32'(io_if.pop_ready), 32'd1);
      tick();
      io_if.pop_valid = 1'b0;
      chk("release_pops", 32'(pop_cnt - p0), 32'd5);
      chk("release_outstanding", 32'(io_if.outstanding), 32'd4);
      io_if.rsp_done = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      io_if.rsp_done = 1'b0;
      chk("credit_return", 32'(io_if.outstanding), 32'd0);
      io_if.pop_valid = 1'b1;
      tick();
      io_if.pop_valid = 1'b0;
      io_if.rsp_done  = 1'b1;
      tick();
      io_if.rsp_done  = 1'b0;
      chk("credit_clean", 32'(io_if.outstanding), 32'd0);

      // Write stuck behind a credit-blocked read; order preserved.
      for (int i = 0; i < 4; i++) push_one(mk(32'h400 + 32'(i), 1'b0));
      io_if.pop_valid = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      for (int i = 0; i < 4; i++) push_one(mk(32'h410 + 32'(i), 1'b0));
      push_one(mk(32'h414, 1'b1));
      p0 = pop_cnt;
      for (int i = 0; i < 3; i++) tick();
      chk("block_pops", 32'(pop_cnt - p0), 32'd0);
      chk("block_level", 32'(io_if.level), 32'd5);
      chk("block_pop_ready", 32'(io_if.pop_ready), 32'd0);
      io_if.rsp_done = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      io_if.rsp_done  = 1'b0;
      io_if.pop_valid = 1'b0;
      chk("order_pops", 32'(pop_cnt - p0), 32'd5);
      chk("order_level", 32'(io_if.level), 32'd0);
      chk("order_outstanding", 32'(io_if.outstanding), 32'd0);
      chk("order_underflow", 32'(io_if.underflow), 32'd0);

      // Steady state: push, pop and completion every cycle.
      push_one(mk(32'h500, 1'b0));
      push_one(mk(32'h501, 1'b0));
      io_if.pop_valid = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         io_if.push_valid = 1'b1;
         io_if.push_req   = mk(32'h510 + 32'(i), 1'b0);
         exp_q.push_back(io_if.push_req);
         io_if.rsp_done   = 1'b1;
         tick();
         chk("steady_level", 32'(io_if.level), 32'd1);
         chk("steady_outstanding", 32'(io_if.outstanding), 32'd1);
      end
      io_if.push_valid = 1'b0;
      io_if.rsp_done   = 1'b0;
      tick();
      io_if.pop_valid = 1'b0;
      chk("steady_drain_outstanding", 32'(io_if.outstanding), 32'd2);
      io_if.rsp_done = 1'b1;
      tick();
      tick();
      io_if.rsp_done = 1'b0;
      chk("steady_clean", 32'(io_if.outstanding), 32'd0);

      // Underflow is sticky; reset mid-stream clears everything.
      io_if.rsp_done = 1'b1;
      tick();
      io_if.rsp_done = 1'b0;
      chk("underflow_set", 32'(io_if.underflow), 32'd1);
      chk("underflow_count", 32'(io_if.outstanding), 32'd0);
      tick();
      chk("underflow_sticky", 32'(io_if.underflow), 32'd1);
      for (int i = 0; i < 5; i++) push_one(mk(32'h600 + 32'(i), 1'b1));
      chk("pre_rst_level", 32'(io_if.level), 32'd5);
      rst = 1'b1;
      tick();
      exp_q.delete();
      chk("mid_rst_level", 32'(io_if.level), 32'd0);
      chk("mid_rst_outstanding", 32'(io_if.outstanding), 32'd0);
      chk("mid_rst_underflow", 32'(io_if.underflow), 32'd0);
      chk("mid_rst_pop_ready", 32'(io_if.pop_ready), 32'd0);
      rst = 1'b0;
      #1;
      push_one(mk(32'h700, 1'b0));
      io_if.pop_valid = 1'b1;
      tick();
      io_if.pop_valid = 1'b0;
      chk("post_rst_outstanding", 32'(io_if.outstanding), 32'd1);
      chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
